// File: rtl/rule_cfg_loader.sv
// Rule-configuration loader: decodes single/burst write commands from a 32-bit
// valid/ready/last word stream and issues registered 64-bit rule write strobes.
module rule_cfg_loader #(
    parameter int CNT_WIDTH = 16,
    parameter int MAX_BURST = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_cfg_valid,
    input  logic [31:0]          i_cfg_data,
    input  logic                 i_cfg_last,
    output logic                 o_cfg_ready,
    output logic                 o_rule_wren,
    output logic [63:0]          o_rule_wdata,
    output logic [31:0]          o_rule_addr,
    output logic [CNT_WIDTH-1:0] o_wr_cnt,
    output logic [2:0]           o_err,
    output logic                 o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DHI,
        S_DLO,
        S_DRAIN
    } state_t;

    localparam logic [7:0] OP_SINGLE = 8'h01;
    localparam logic [7:0] OP_BURST  = 8'h02;

    state_t      state, state_nxt;
    logic        xfer;
    logic [7:0]  remaining;
    logic [31:0] addr;
    logic [31:0] data_hi;
    logic [7:0]  hdr_opcode;
    logic [7:0]  hdr_count;
    logic        hdr_bad;
    logic        load_hdr;
    logic        do_write;
    logic [2:0]  err_set;

    assign xfer       = i_cfg_valid & i_en;
    assign hdr_opcode = i_cfg_data[31:24];
    assign hdr_count  = i_cfg_data[7:0];
    assign hdr_bad    = !((hdr_opcode == OP_SINGLE) ||
                          ((hdr_opcode == OP_BURST) && (hdr_count != 8'd0) &&
                           (int'(hdr_count) <= MAX_BURST)));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every variable gets a default at the top of always_comb, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        load_hdr  = 1'b0;
        do_write  = 1'b0;
        err_set   = 3'b000;
        if (xfer) begin
            unique case (state)
                S_IDLE: begin
                    if (hdr_bad) begin
                        err_set[0] = 1'b1;
                        state_nxt  = i_cfg_last ? S_IDLE : S_DRAIN;
                    end else if (i_cfg_last) begin
                        err_set[1] = 1'b1;
                    end else begin
                        load_hdr  = 1'b1;
                        state_nxt = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (i_cfg_last) begin
                        err_set[1] = 1'b1;
                        state_nxt  = S_IDLE;
                    end else begin
                        state_nxt = S_DHI;
                    end
                end
                S_DHI: begin
                    if (i_cfg_last) begin
                        err_set[1] = 1'b1;
                        state_nxt  = S_IDLE;
                    end else begin
                        state_nxt = S_DLO;
                    end
                end
                S_DLO: begin
                    // A data_lo word always completes its write, even with an early last.
                    do_write = 1'b1;
                    if (remaining == 8'd1) begin
                        if (i_cfg_last) begin
                            state_nxt = S_IDLE;
                        end else begin
                            err_set[2] = 1'b1;
                            state_nxt  = S_DRAIN;
                        end
                    end else if (i_cfg_last) begin
                        err_set[1] = 1'b1;
                        state_nxt  = S_IDLE;
                    end else begin
                        state_nxt = S_DHI;
                    end
                end
                S_DRAIN: begin
                    if (i_cfg_last) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_cfg_ready = i_en;
        o_busy      = (state != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            remaining    <= '0;
            addr         <= '0;
            data_hi      <= '0;
            o_rule_wren  <= 1'b0;
            o_rule_wdata <= '0;
            o_rule_addr  <= '0;
            o_wr_cnt     <= '0;
            o_err        <= '0;
        end else begin
            o_rule_wren <= do_write;
            o_err       <= o_err | err_set;
            if (load_hdr)
                remaining <= (hdr_opcode == OP_BURST) ? hdr_count : 8'd1;
            if (xfer && state == S_ADDR)
                addr <= i_cfg_data;
            if (xfer && state == S_DHI)
                data_hi <= i_cfg_data;
            if (do_write) begin
                o_rule_addr  <= addr;
                o_rule_wdata <= {data_hi, i_cfg_data};
                o_wr_cnt     <= o_wr_cnt + CNT_WIDTH'(1);
                remaining    <= remaining - 8'd1;
                addr         <= addr + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_rule_cfg_loader.sv
// Self-checking bench for rule_cfg_loader: table of single writes plus
// hand-written burst/error/enable/reset sequences, writes checked via a queue.
`timescale 1ns/1ps
module tb_rule_cfg_loader;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_en = 1'b1;
    logic        i_cfg_valid = 1'b0;
    logic [31:0] i_cfg_data = '0;
    logic        i_cfg_last = 1'b0;
    logic        o_cfg_ready;
    logic        o_rule_wren;
    logic [63:0] o_rule_wdata;
    logic [31:0] o_rule_addr;
    logic [15:0] o_wr_cnt;
    logic [2:0]  o_err;
    logic        o_busy;

    rule_cfg_loader #(.CNT_WIDTH(16), .MAX_BURST(255)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_cfg_valid  (i_cfg_valid),
        .i_cfg_data   (i_cfg_data),
        .i_cfg_last   (i_cfg_last),
        .o_cfg_ready  (o_cfg_ready),
        .o_rule_wren  (o_rule_wren),
        .o_rule_wdata (o_rule_wdata),
        .o_rule_addr  (o_rule_addr),
        .o_wr_cnt     (o_wr_cnt),
        .o_err        (o_err),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] addr;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [15:0] exp_cnt;
        logic [2:0]  exp_err;
    } vec_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    vec_t        vecs[3];
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt = '0;
    logic [2:0]  exp_err = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        @(negedge i_clk);
        i_cfg_valid = 1'b1;
        i_cfg_data  = d;
        i_cfg_last  = l;
        @(posedge i_clk);
        #1;
        i_cfg_valid = 1'b0;
        i_cfg_last  = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] hi, input logic [31:0] lo);
        wr_t w;
        w.addr = a;
        w.data = {hi, lo};
        exp_q.push_back(w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_cnt"}, o_wr_cnt, exp_cnt);
        check({tag, "_err"}, o_err, exp_err);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expected write.
    always @(negedge i_clk) begin
        if (!i_rst && o_rule_wren) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wren", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", o_rule_addr, mon_e.addr);
                check("wr_data", o_rule_wdata, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0100_0000, 32'h0001_0103, 32'h0000_00AB, 32'h0000_0012, 16'd1, 3'b000};
        vecs[1] = '{32'h0100_0005, 32'h8000_0000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 16'd2, 3'b000};
        vecs[2] = '{32'h0100_00FF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 16'd3, 3'b000};

        idle(2);
        check("rst_wren", o_rule_wren, 0);
        check("rst_wdata", o_rule_wdata, 0);
        check("rst_addr", o_rule_addr, 0);
        check("rst_cnt", o_wr_cnt, 0);
        check("rst_err", o_err, 0);
        check("rst_busy", o_busy, 0);
        i_rst = 1'b0;
        idle(1);
        check("ready_en", o_cfg_ready, 1);

        // Table of single writes: strobe lands exactly one cycle after data_lo.
        for (int i = 0; i < 3; i++) begin
            send(vecs[i].hdr, 1'b0);
            send(vecs[i].addr, 1'b0);
            send(vecs[i].hi, 1'b0);
            push_wr(vecs[i].addr, vecs[i].hi, vecs[i].lo);
            send(vecs[i].lo, 1'b1);
            @(negedge i_clk);
            check("wren_latency", o_rule_wren, 1);
            @(negedge i_clk);
            check("wren_one_cycle", o_rule_wren, 0);
            check("vec_cnt", o_wr_cnt, vecs[i].exp_cnt);
            check("vec_err", o_err, vecs[i].exp_err);
            check("vec_busy", o_busy, 0);
        end
        exp_cnt = 16'd3;

        // Burst of 3.
        send(32'h0200_0003, 1'b0);
        send(32'h0001_0200, 1'b0);
        for (int k = 0; k < 3; k++) begin
            send(32'(2 * k + 1), 1'b0);
            push_wr(32'h0001_0200 + 32'(k), 32'(2 * k + 1), 32'(2 * k + 2));
            send(32'(2 * k + 2), k == 2);
        end
        idle(2);
        exp_cnt = exp_cnt + 16'd3;
        check_status("burst3");

        // Bad opcode drained, then a good single write.
        send(32'h0700_0000, 1'b0);
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b0);
        @(negedge i_clk);
        check("drain_busy", o_busy, 1);
        send(32'h3333_3333, 1'b1);
        idle(2);
        exp_err = exp_err | 3'b001;
        check_status("badop");
        send(32'h0100_0000, 1'b0);
        send(32'h0000_0400, 1'b0);
        send(32'h0000_0077, 1'b0);
        push_wr(32'h0000_0400, 32'h0000_0077, 32'h0000_0088);
        send(32'h0000_0088, 1'b1);
        idle(2);
        exp_cnt = exp_cnt + 16'd1;
        check_status("after_bad");

        // Burst of 2 with last on the first data_lo: one write, early-last error.
        send(32'h0200_0002, 1'b0);
        send(32'h0000_0500, 1'b0);
        send(32'h0000_00A1, 1'b0);
        push_wr(32'h0000_0500, 32'h0000_00A1, 32'h0000_00A2);
        send(32'h0000_00A2, 1'b1);
        idle(2);
        exp_cnt = exp_cnt + 16'd1;
        exp_err = exp_err | 3'b010;
        check_status("early_last");

        // Single write missing last: write issued, trailing words discarded.
        send(32'h0100_0000, 1'b0);
        send(32'h0000_0600, 1'b0);
        send(32'h0000_00B1, 1'b0);
        push_wr(32'h0000_0600, 32'h0000_00B1, 32'h0000_00B2);
        send(32'h0000_00B2, 1'b0);
        @(negedge i_clk);
        check("missing_last_busy", o_busy, 1);
        send(32'h0000_00C1, 1'b0);
        send(32'h0000_00C2, 1'b1);
        idle(2);
        exp_cnt = exp_cnt + 16'd1;
        exp_err = exp_err | 3'b100;
        check_status("missing_last");

        // Address wrap across 0xFFFFFFFF.
        send(32'h0200_0002, 1'b0);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h0000_0011, 1'b0);
        push_wr(32'hFFFF_FFFF, 32'h0000_0011, 32'h0000_0022);
        send(32'h0000_0022, 1'b0);
        send(32'h0000_0033, 1'b0);
        push_wr(32'h0000_0000, 32'h0000_0033, 32'h0000_0044);
        send(32'h0000_0044, 1'b1);
        idle(2);
        exp_cnt = exp_cnt + 16'd2;
        check_status("wrap");

        // Enable dropped for 5 cycles with data_lo pending.
        send(32'h0100_0000, 1'b0);
        send(32'h0000_0700, 1'b0);
        send(32'h0000_00D1, 1'b0);
        push_wr(32'h0000_0700, 32'h0000_00D1, 32'h0000_00D2);
        @(negedge i_clk);
        i_en        = 1'b0;
        i_cfg_valid = 1'b1;
        i_cfg_data  = 32'h0000_00D2;
        i_cfg_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            check("en_off_ready", o_cfg_ready, 0);
            check("en_off_wren", o_rule_wren, 0);
            check("en_off_busy", o_busy, 1);
        end
        i_en = 1'b1;
        @(posedge i_clk);
        #1;
        i_cfg_valid = 1'b0;
        i_cfg_last  = 1'b0;
        @(negedge i_clk);
        check("en_resume_wren", o_rule_wren, 1);
        idle(1);
        exp_cnt = exp_cnt + 16'd1;
        check_status("en_drop");

        // Reset after the ADDR word of a burst: abandon, then decode fresh.
        send(32'h0200_0002, 1'b0);
        send(32'h0000_0800, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("mid_rst_wren", o_rule_wren, 0);
        check("mid_rst_wdata", o_rule_wdata, 0);
        check("mid_rst_addr", o_rule_addr, 0);
        check("mid_rst_cnt", o_wr_cnt, 0);
        check("mid_rst_err", o_err, 0);
        check("mid_rst_busy", o_busy, 0);
        i_rst   = 1'b0;
        exp_cnt = '0;
        exp_err = '0;
        send(32'h0100_0000, 1'b0);
        send(32'h0000_0900, 1'b0);
        send(32'h0000_00E1, 1'b0);
        push_wr(32'h0000_0900, 32'h0000_00E1, 32'h0000_00E2);
        send(32'h0000_00E2, 1'b1);
        idle(2);
        exp_cnt = exp_cnt + 16'd1;
        check_status("post_rst");

        idle(3);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rule_cfg_loader.md
Name: rule_cfg_loader

Overview:
- Upstream feeder of the rule-configuration stage of the 3-stage parser.
- Receives a 32-bit configuration word stream (valid/ready/last) from the host/DMA side and decodes single and burst write commands.
- Emits one-cycle rule write strobes with 64-bit data and 32-bit address, and reports write count and sticky error status.

Parameters:
- CNT_WIDTH, 16, width of the completed-write counter o_wr_cnt.
- MAX_BURST, 255, largest legal burst length; header count values above this are errors.

Ports:
- i_clk  input  1  clock; all logic on its rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_en  input  1  loader enable; when 0, o_cfg_ready=0 and the FSM holds its state.
- i_cfg_valid  input  1  stream word valid.
- i_cfg_data  input  32  stream word.
- i_cfg_last  input  1  marks the last word of a command.
- o_cfg_ready  output  1  stream ready; equals i_en (combinational); a word transfers when valid&ready.
- o_rule_wren  output  1  one-cycle write strobe to the rule-configuration stage.
- o_rule_wdata  output  64  write data; valid while o_rule_wren=1.
- o_rule_addr  output  32  write address; valid while o_rule_wren=1.
- o_wr_cnt  output  CNT_WIDTH  number of writes issued since reset; wraps.
- o_err  output  3  sticky errors: bit0 bad opcode/count, bit1 early last, bit2 missing last.
- o_busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async, i_rst=1): FSM=IDLE; o_rule_wren=0; o_rule_wdata=0; o_rule_addr=0; o_wr_cnt=0; o_err=0; o_busy=0; internal counters=0.
- Command format:
  - Word0 header: [31:24] opcode (0x01 single write, 0x02 burst), [7:0] count; count is ignored for single, forced to 1.
  - Word1: start address.
  - Then count pairs: data_hi word, then data_lo word. o_rule_wdata = {data_hi, data_lo}.
- FSM states: IDLE, ADDR, DHI, DLO, DRAIN. Transitions occur only on a transfer (valid&ready).
- IDLE:
  - On header: if opcode ∉ {01,02}, or opcode=02 with count=0 or count>MAX_BURST, set o_err[0] and go to DRAIN; if last=1 on that word, go to IDLE instead.
  - Otherwise latch remaining=count, go to ADDR.
- ADDR: latch the address, go to DHI.
- DHI: latch data_hi, go to DLO.
- DLO: the write is registered, so o_rule_wren=1 in the cycle after the data_lo transfer, with o_rule_addr = current address and wdata as assembled. In the same edge: o_wr_cnt+1, remaining-1, address+1 (32-bit, wraps 0xFFFFFFFF→0). Then:
  - remaining was 1 and last=1: go to IDLE.
  - remaining was 1 and last=0: set o_err[2], go to DRAIN.
  - remaining >1: go to DHI.
- Early last: if last=1 on any header/ADDR/DHI word, or on a DLO word with remaining>1, set o_err[1] and go to IDLE.
  - A data_lo word carrying early last still issues its write.
  - A header with legal opcode and last=1 also sets o_err[1].
- DRAIN: discard words until a word with last=1 transfers, then go to IDLE. No writes in DRAIN.
- o_rule_wren is high for exactly one cycle per write. Back-to-back writes are at most one per 2 accepted words. o_rule_addr/o_rule_wdata hold their last values between writes.
- i_en=0 mid-command: no transfers; state, partial data and remaining are preserved; resumes on i_en=1.
- Reset mid-command: command is abandoned, no strobe is issued, and state returns to IDLE.
- o_err bits are cleared only by reset. o_busy=(state≠IDLE).

Test Plan:
- Single write: stream {0x01000000, 0x00010103, 0x0000_00AB, 0x0000_0012 last} → exactly one o_rule_wren pulse one cycle after the 4th word, addr=0x00010103, wdata=0x000000AB_00000012, o_wr_cnt=1, o_err=0.
- Burst of 3 at addr 0x00010200 with data pairs (1,2),(3,4),(5,6), last on the final word → 3 strobes with addrs 0x00010200/201/202, wdata 0x1_00000002 / 0x3_00000004 / 0x5_00000006, o_wr_cnt=3.
- Bad opcode 0x07 header followed by 3 words, last on the 3rd → no strobe, o_err=3'b001, back to IDLE; a following good single write succeeds.
- Burst count=2 with last on the first data_lo → one strobe, o_err[1]=1, FSM IDLE. Separately, single write without last, then 2 words with last on the 2nd → one strobe, o_err[2]=1, the trailing words are discarded.
- Address wrap: burst of 2 at 0xFFFFFFFF → addrs 0xFFFFFFFF then 0x00000000. i_en dropped for 5 cycles between DHI and DLO → o_cfg_ready=0 during those cycles, and the correct single strobe follows afterward.
- i_rst pulsed after ADDR word of a burst → no strobe, all outputs at reset values, next command decoded from a fresh header.
